// File: rtl/wb_test_monitor.sv
// ---------------------------------------------------------------------------
// wb_test_monitor
//
// Test-completion monitor for the writeback stage of the RV32I/M pipeline.
// Every cycle it samples the writeback bus and does three things:
//   - pushes signature words into a small FIFO;
//   - detects the halt marker;
//   - runs a cycle-count watchdog.
// A bench or debug port drains the FIFO and watches the sticky status flags
// to decide when to stop the run.
//
// Configuration macro: WB_TEST_MONITOR_TIMEOUT_EN
//   defined   - the watchdog moves the monitor to TIMEOUT after TIMEOUT cycles
//   undefined - timeout stays 0 and only the halt marker ends RUN
//
// Ports
//   clk           in   clock
//   rst           in   asynchronous reset, active-low
//   wb_valid      in   writeback slot valid
//   wb_wr         in   instruction is a store (sample ignored when 1)
//   wb_data       in   writeback result
//   sig_rd_en     in   pop request
//   sig_rd_data   out  popped word (registered)
//   sig_rd_valid  out  sig_rd_data valid this cycle
//   sig_count     out  FIFO occupancy
//   sig_empty     out  occupancy == 0
//   sig_full      out  occupancy == SIG_DEPTH
//   overflow      out  sticky: a capture was dropped
//   halted        out  sticky: halt marker seen
//   timeout       out  sticky: watchdog expired
//   cycle_count   out  cycles spent in RUN (saturating)
// ---------------------------------------------------------------------------
module wb_test_monitor #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       SIG_DEPTH = 16,
    parameter logic [DATA_W-1:0] SIG_MARK  = 32'h00000f00,
    parameter logic [DATA_W-1:0] SIG_MASK  = 32'hffffffff,
    parameter logic [DATA_W-1:0] HALT_MARK = 32'hcafebeef,
    parameter int unsigned       TIMEOUT   = 500,
    parameter int unsigned       CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_valid,
    input  logic                         wb_wr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         sig_rd_en,
    output logic [DATA_W-1:0]            sig_rd_data,
    output logic                         sig_rd_valid,
    output logic [$clog2(SIG_DEPTH):0]   sig_count,
    output logic                         sig_empty,
    output logic                         sig_full,
    output logic                         overflow,
    output logic                         halted,
    output logic                         timeout,
    output logic [CNT_W-1:0]             cycle_count
);

    // Pointers address SIG_DEPTH entries; the occupancy counter is one bit
    // wider so that "full" (== SIG_DEPTH) is representable.
    localparam int unsigned PTR_W  = $clog2(SIG_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SIG_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e               state_q;
    logic [CNT_W-1:0]     cycle_count_q;
    logic                 halted_q;
    logic                 timeout_q;

    logic [DATA_W-1:0]    mem_q [SIG_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [OCC_W-1:0]     occ_q,      occ_d;
    logic                 overflow_q, overflow_d;
    logic [DATA_W-1:0]    rd_data_q,  rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    // -----------------------------------------------------------------------
    // Sample decode
    // -----------------------------------------------------------------------
    logic in_run;
    logic qualified;
    logic halt_hit;
    logic sig_hit;
    logic wdog_hit;
    logic cnt_sat;

    assign in_run    = (state_q == ST_RUN);
    assign qualified = wb_valid & ~wb_wr;
    assign halt_hit  = in_run & qualified & (wb_data == HALT_MARK);
    // A word that is also the halt marker is never captured.
    assign sig_hit   = in_run & qualified & ~halt_hit &
                       ((wb_data & SIG_MASK) == (SIG_MARK & SIG_MASK));
    assign cnt_sat   = &cycle_count_q;

`ifdef WB_TEST_MONITOR_TIMEOUT_EN
    // Fires on the edge where the counter moves from TIMEOUT-1 to TIMEOUT;
    // a coincident halt takes priority.
    assign wdog_hit  = in_run & ~halt_hit &
                       (cycle_count_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign wdog_hit  = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Run-control FSM, cycle counter and sticky termination flags
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            cycle_count_q <= '0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // The terminating cycle is itself a RUN cycle and counts.
                    if (!cnt_sat) begin
                        cycle_count_q <= cycle_count_q + CNT_W'(1);
                    end
                    if (halt_hit) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (wdog_hit) begin
                        state_q   <= ST_TIMEOUT;
                        timeout_q <= 1'b1;
                    end
                end
                ST_HALTED,
                ST_TIMEOUT: begin
                    // Terminal: counter frozen, only reset leaves.
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Signature FIFO control
    // -----------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic do_pop;
    logic do_push;
    logic drop;

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == OCC_FULL);
    assign do_pop     = sig_rd_en & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push    = sig_hit & (~fifo_full | do_pop);
    assign drop       = sig_hit & fifo_full & ~do_pop;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q | drop;
        rd_valid_d = do_pop;
        rd_data_d  = rd_data_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end

        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers and the
    // occupancy is enough to discard its contents, and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wb_data;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign sig_rd_data  = rd_data_q;
    assign sig_rd_valid = rd_valid_q;
    assign sig_count    = occ_q;
    assign sig_empty    = fifo_empty;
    assign sig_full     = fifo_full;
    assign overflow     = overflow_q;
    assign halted       = halted_q;
    assign timeout      = timeout_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_wb_test_monitor.sv
// ---------------------------------------------------------------------------
// tb_wb_test_monitor
//
// Directed bench for wb_test_monitor with SIG_DEPTH = 4 and TIMEOUT = 20.
// SIG_MASK is widened to ignore the low byte so that distinct words
// (32'h00000f00 .. 32'h00000fff) all qualify as signatures and FIFO ordering
// can be observed. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_wb_test_monitor;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned SIG_DEPTH = 4;
    localparam int unsigned TIMEOUT   = 20;
    localparam int unsigned CNT_W     = 32;
    localparam logic [31:0] SIG_W     = 32'h00000f00;
    localparam logic [31:0] HALT_W    = 32'hcafebeef;

`ifdef WB_TEST_MONITOR_TIMEOUT_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic                       clk;
    logic                       rst;
    logic                       wb_valid;
    logic                       wb_wr;
    logic [DATA_W-1:0]          wb_data;
    logic                       sig_rd_en;
    logic [DATA_W-1:0]          sig_rd_data;
    logic                       sig_rd_valid;
    logic [$clog2(SIG_DEPTH):0] sig_count;
    logic                       sig_empty;
    logic                       sig_full;
    logic                       overflow;
    logic                       halted;
    logic                       timeout;
    logic [CNT_W-1:0]           cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    wb_test_monitor #(
        .DATA_W    (DATA_W),
        .SIG_DEPTH (SIG_DEPTH),
        .SIG_MARK  (SIG_W),
        .SIG_MASK  (32'hffffff00),
        .HALT_MARK (HALT_W),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_wr        (wb_wr),
        .wb_data      (wb_data),
        .sig_rd_en    (sig_rd_en),
        .sig_rd_data  (sig_rd_data),
        .sig_rd_valid (sig_rd_valid),
        .sig_count    (sig_count),
        .sig_empty    (sig_empty),
        .sig_full     (sig_full),
        .overflow     (overflow),
        .halted       (halted),
        .timeout      (timeout),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid  = 1'b0;
        wb_wr     = 1'b0;
        wb_data   = '0;
        sig_rd_en = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".cycle_count"},  cycle_count,  0);
        check({tag, ".sig_rd_data"},  sig_rd_data,  0);
        check({tag, ".sig_rd_valid"}, sig_rd_valid, 0);
        check({tag, ".sig_count"},    sig_count,    0);
        check({tag, ".sig_empty"},    sig_empty,    1);
        check({tag, ".sig_full"},     sig_full,     0);
        check({tag, ".overflow"},     overflow,     0);
        check({tag, ".halted"},       halted,       0);
        check({tag, ".timeout"},      timeout,      0);
    endtask

    // Asserts reset between clock edges, checks the asynchronous clear,
    // then releases 1 time unit after the next rising edge.
    task automatic do_reset(input string tag);
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        check_reset_values(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();

        // ---------------- capture and drain in order ----------------------
        do_reset("rst_init");
        wb_valid = 1'b1;
        wb_data = 32'h00000f00; tick();
        check("cap1.count", sig_count, 1);
        check("cap1.empty", sig_empty, 0);
        wb_data = 32'h00000f01; tick();
        check("cap2.count", sig_count, 2);
        wb_data = 32'h00000f02; tick();
        check("cap3.count", sig_count, 3);
        check("cap3.full",  sig_full,  0);
        // Qualified but not a signature: masked value 32'h00001f00.
        wb_data = 32'h00001f00; tick();
        check("nomatch.count", sig_count, 3);
        wb_valid = 1'b0;

        sig_rd_en = 1'b1; tick();
        check("pop1.valid", sig_rd_valid, 1);
        check("pop1.data",  sig_rd_data,  32'h00000f00);
        check("pop1.count", sig_count,    2);
        sig_rd_en = 1'b0; tick();
        check("pop1.valid_drop", sig_rd_valid, 0);
        check("pop1.data_hold",  sig_rd_data,  32'h00000f00);
        sig_rd_en = 1'b1; tick();
        check("pop2.valid", sig_rd_valid, 1);
        check("pop2.data",  sig_rd_data,  32'h00000f01);
        sig_rd_en = 1'b0; tick();
        check("pop2.valid_drop", sig_rd_valid, 0);
        sig_rd_en = 1'b1; tick();
        check("pop3.valid", sig_rd_valid, 1);
        check("pop3.data",  sig_rd_data,  32'h00000f02);
        check("pop3.empty", sig_empty,    1);
        // Pop on empty: no valid, data holds, no counter underflow.
        tick();
        check("pop_empty.valid", sig_rd_valid, 0);
        check("pop_empty.data",  sig_rd_data,  32'h00000f02);
        check("pop_empty.count", sig_count,    0);
        sig_rd_en = 1'b0;

        // ---------------- halt marker after 10 cycles ---------------------
        do_reset("rst_halt");
        repeat (10) tick();
        check("pre_halt.cycle",  cycle_count, 10);
        check("pre_halt.halted", halted,      0);
        wb_valid = 1'b1; wb_data = HALT_W; tick();
        check("halt.halted",  halted,      1);
        check("halt.cycle",   cycle_count, 11);
        check("halt.count",   sig_count,   0);
        check("halt.timeout", timeout,     0);
        wb_data = SIG_W; tick();
        check("post_halt.nocap", sig_count,   0);
        check("post_halt.cycle", cycle_count, 11);
        wb_valid = 1'b0;
        repeat (3) tick();
        check("post_halt.frozen", cycle_count, 11);
        check("post_halt.sticky", halted,      1);

        // ---------------- watchdog ----------------------------------------
        do_reset("rst_wdog");
        repeat (19) tick();
        check("wdog19.cycle",   cycle_count, 19);
        check("wdog19.timeout", timeout,     0);
        tick();
        check("wdog20.cycle",   cycle_count, 20);
        check("wdog20.timeout", timeout,     WDOG);
        repeat (3) tick();
        check("wdog23.cycle",   cycle_count, WDOG ? 20 : 23);
        check("wdog23.timeout", timeout,     WDOG);
        wb_valid = 1'b1; wb_data = SIG_W; tick();
        check("wdog_cap.count",  sig_count, WDOG ? 0 : 1);
        check("wdog_cap.halted", halted,    0);
        wb_valid = 1'b0;

        // ---------------- halt coincides with watchdog --------------------
        do_reset("rst_coinc");
        repeat (19) tick();
        wb_valid = 1'b1; wb_data = HALT_W; tick();
        check("coinc.halted",  halted,      1);
        check("coinc.timeout", timeout,     0);
        check("coinc.cycle",   cycle_count, 20);
        wb_valid = 1'b0;
        repeat (2) tick();
        check("coinc.timeout_later", timeout, 0);

        // ---------------- FIFO full / overflow ----------------------------
        do_reset("rst_ovf");
        wb_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_data = 32'h00000f00 + 32'(i);
            tick();
            check($sformatf("fill%0d.count", i), sig_count, 64'(i + 1));
        end
        check("fill.full",     sig_full, 1);
        check("fill.overflow", overflow, 0);
        wb_data = 32'h00000f04; tick();
        check("drop.count",    sig_count, 4);
        check("drop.overflow", overflow,  1);
        check("drop.full",     sig_full,  1);
        // Push and pop while full: both succeed.
        wb_data = 32'h00000f05; sig_rd_en = 1'b1; tick();
        check("pushpop.count",    sig_count,    4);
        check("pushpop.valid",    sig_rd_valid, 1);
        check("pushpop.data",     sig_rd_data,  32'h00000f00);
        check("pushpop.overflow", overflow,     1);
        wb_valid = 1'b0;
        tick();
        check("drain0.data", sig_rd_data, 32'h00000f01);
        tick();
        check("drain1.data", sig_rd_data, 32'h00000f02);
        tick();
        check("drain2.data", sig_rd_data, 32'h00000f03);
        tick();
        check("drain3.data",  sig_rd_data,  32'h00000f05);
        check("drain3.valid", sig_rd_valid, 1);
        check("drain3.empty", sig_empty,    1);
        sig_rd_en = 1'b0; tick();
        check("drain.valid_drop",  sig_rd_valid, 0);
        check("drain.overflow",    overflow,     1);

        // ---------------- stores and invalid slots ignored ----------------
        do_reset("rst_qual");
        wb_valid = 1'b1; wb_wr = 1'b1; wb_data = HALT_W; tick();
        check("store_halt.halted", halted,    0);
        check("store_halt.count",  sig_count, 0);
        wb_valid = 1'b0; wb_wr = 1'b0; wb_data = SIG_W; tick();
        check("invalid_sig.count", sig_count, 0);
        wb_valid = 1'b0; wb_wr = 1'b0; wb_data = HALT_W; tick();
        check("invalid_halt.halted", halted, 0);
        wb_valid = 1'b1; wb_wr = 1'b1; wb_data = SIG_W; tick();
        check("store_sig.count", sig_count, 0);
        wb_wr = 1'b0; tick();
        check("qual_sig.count", sig_count, 1);
        wb_valid = 1'b0;

        // ---------------- reset mid-run clears everything -----------------
        do_reset("rst_pre_mid");
        wb_valid = 1'b1;
        wb_data = 32'h00000f00; tick();
        wb_data = 32'h00000f01; tick();
        wb_data = HALT_W;       tick();
        check("mid.halted", halted,      1);
        check("mid.count",  sig_count,   2);
        check("mid.cycle",  cycle_count, 3);
        wb_valid = 1'b0;
        // Reads are still serviced in HALTED.
        sig_rd_en = 1'b1; tick();
        check("mid_pop.valid", sig_rd_valid, 1);
        check("mid_pop.data",  sig_rd_data,  32'h00000f00);
        check("mid_pop.count", sig_count,    1);
        do_reset("rst_mid");
        wb_valid = 1'b1; wb_data = 32'h00000f07; tick();
        check("after_rst.count", sig_count,   1);
        check("after_rst.cycle", cycle_count, 1);
        wb_valid = 1'b0; sig_rd_en = 1'b1; tick();
        check("after_rst.data",  sig_rd_data,  32'h00000f07);
        check("after_rst.valid", sig_rd_valid, 1);
        sig_rd_en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
